// File: rtl/mkio_transmitter.sv
// MIL-STD-1553 (MKIO) Manchester-II word encoder: 3-bit sync, 16 data bits MSB first, odd parity.
// Optional MKIO_TX_PARITY_INJECT_EN adds inject_perr to send an inverted parity bit for one word.
module mkio_transmitter #(
    parameter int unsigned CLK_FREQ_HZ = 16_000_000,
    parameter int unsigned BIT_RATE_HZ = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_ready,
    input  logic [15:0] tx_data,
    input  logic        tx_cd,
`ifdef MKIO_TX_PARITY_INJECT_EN
    input  logic        inject_perr,
`endif
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_out_p,
    output logic        tx_out_n
);

    localparam int unsigned HALF_BIT = CLK_FREQ_HZ / (2 * BIT_RATE_HZ);
    localparam int unsigned DivW     = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(HALF_BIT - 1);

    typedef enum logic [1:0] {StIdle, StSync, StData, StParity} state_e;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q, div_d;
    logic [4:0]      hb_q, hb_d;
    logic [15:0]     shift_q, shift_d;
    logic            cd_q, cd_d;
    logic            par_q, par_d;
    logic            pend_q, pend_d;
    logic            p_q, n_q, busy_q, done_q;
    logic            level_d, busy_d, done_d;
    logic            last_div, window, accept, inj_cur;

    assign last_div = (div_q == DivLast);
    assign window   = (state_q == StIdle) || ((state_q == StParity) && (hb_q == 5'd1));
    assign accept   = tx_ready && window;

`ifdef MKIO_TX_PARITY_INJECT_EN
    logic inj_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inj_q <= 1'b0;
        end else if (accept) begin
            inj_q <= inject_perr;
        end
    end
    assign inj_cur = inj_q;
`else
    assign inj_cur = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        div_d   = last_div ? '0 : div_q + 1'b1;
        hb_d    = hb_q;
        shift_d = shift_q;
        cd_d    = cd_q;
        par_d   = par_q;
        pend_d  = pend_q;

        // The shifter and sync type are free during parity, so a new word may load them early.
        if (accept) begin
            shift_d = tx_data;
            cd_d    = tx_cd;
        end

        unique case (state_q)
            StIdle: begin
                div_d = '0;
                hb_d  = '0;
                if (accept) state_d = StSync;
            end
            StSync: begin
                if (last_div) begin
                    if (hb_q == 5'd5) begin
                        state_d = StData;
                        hb_d    = '0;
                        par_d   = ~inj_cur;
                    end else begin
                        hb_d = hb_q + 5'd1;
                    end
                end
            end
            StData: begin
                if (last_div) begin
                    // Parity accumulates as each data bit completes.
                    if (hb_q[0]) begin
                        shift_d = {shift_q[14:0], 1'b0};
                        par_d   = par_q ^ shift_q[15];
                    end
                    if (hb_q == 5'd31) begin
                        state_d = StParity;
                        hb_d    = '0;
                    end else begin
                        hb_d = hb_q + 5'd1;
                    end
                end
            end
            StParity: begin
                if (accept && !last_div) pend_d = 1'b1;
                if (last_div) begin
                    if (hb_q == 5'd0) begin
                        hb_d = 5'd1;
                    end else if (pend_q || accept) begin
                        state_d = StSync;
                        hb_d    = '0;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = StIdle;
                        hb_d    = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        level_d = 1'b0;
        unique case (state_d)
            StSync:   level_d = (hb_d < 5'd3) ^ cd_d;
            StData:   level_d = shift_d[15] ^ hb_d[0];
            StParity: level_d = par_d ^ hb_d[0];
            default:  level_d = 1'b0;
        endcase

        busy_d = (state_d != StIdle) &&
                 !((state_d == StParity) && (hb_d == 5'd1) && !pend_d);
        done_d = (state_d == StParity) && (hb_d == 5'd1) && (div_d == DivLast);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            div_q   <= '0;
            hb_q    <= '0;
            shift_q <= '0;
            cd_q    <= 1'b0;
            par_q   <= 1'b0;
            pend_q  <= 1'b0;
            p_q     <= 1'b0;
            n_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            hb_q    <= hb_d;
            shift_q <= shift_d;
            cd_q    <= cd_d;
            par_q   <= par_d;
            pend_q  <= pend_d;
            p_q     <= (state_d != StIdle) && level_d;
            n_q     <= (state_d != StIdle) && !level_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx_out_p = p_q;
    assign tx_out_n = n_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_mkio_transmitter.sv
// Randomized bench for mkio_transmitter against a half-bit level model of the 1553 word.
// Define MKIO_TX_PARITY_INJECT_EN to also exercise inject_perr.
module tb_mkio_transmitter;

    localparam int H = 8;
`ifdef MKIO_TX_PARITY_INJECT_EN
    localparam bit InjOn = 1'b1;
`else
    localparam bit InjOn = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        tx_ready;
    logic [15:0] tx_data;
    logic        tx_cd;
`ifdef MKIO_TX_PARITY_INJECT_EN
    logic        inject_perr;
`endif
    logic        tx_busy, tx_done, tx_out_p, tx_out_n;

    int n_checks = 0;
    int n_errors = 0;

    mkio_transmitter dut (
        .clk         (clk),
        .reset       (reset),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_cd       (tx_cd),
`ifdef MKIO_TX_PARITY_INJECT_EN
        .inject_perr (inject_perr),
`endif
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_out_p    (tx_out_p),
        .tx_out_n    (tx_out_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Half-bit i of the word; 1 = "high" (p=1,n=0), 0 = "low" (p=0,n=1).
    function automatic logic [39:0] model_word(input logic [15:0] d, input logic cd,
                                               input logic inj);
        logic [39:0] w;
        logic        par;
        for (int i = 0; i < 3; i++) w[i] = ~cd;
        for (int i = 3; i < 6; i++) w[i] = cd;
        for (int b = 0; b < 16; b++) begin
            w[6 + 2*b] = d[15 - b];
            w[7 + 2*b] = ~d[15 - b];
        end
        par   = (($countones(d) % 2) == 0) ^ inj;
        w[38] = par;
        w[39] = ~par;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] d, input logic cd, input logic inj);
        tx_ready = 1'b1;
        tx_data  = d;
        tx_cd    = cd;
`ifdef MKIO_TX_PARITY_INJECT_EN
        inject_perr = inj;
`else
        if (inj) tx_cd = cd;
`endif
    endtask

    task automatic scramble();
        tx_ready = 1'b0;
        tx_data  = 16'($urandom);
        tx_cd    = 1'($urandom);
`ifdef MKIO_TX_PARITY_INJECT_EN
        inject_perr = 1'($urandom);
`endif
    endtask

    task automatic start_idle(input logic [15:0] d, input logic cd, input logic inj);
        drive(d, cd, inj);
        tick();
        scramble();
    endtask

    task automatic check_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, {28'd0, tx_out_p, tx_out_n, tx_busy, tx_done}, 32'd0);
            tick();
        end
    endtask

    // Called with cycle 0 of the word on the line; returns with the cycle after the word showing.
    task automatic run_word(input string tag, input logic [15:0] d, input logic cd,
                            input logic inj, input logic chain, input logic [15:0] nd,
                            input logic ncd, input logic ninj, input int win_k,
                            input int stray_k, input logic [15:0] stray_d, input int abort_at);
        logic [39:0] w;
        logic        lvl, eb, ed;
        int          wk;
        w  = model_word(d, cd, InjOn & inj);
        wk = (win_k >= 0) ? win_k : 39*H + $urandom_range(0, H-1);
        for (int k = 0; k < 40*H; k++) begin
            if (k == abort_at) return;
            lvl = w[k / H];
            eb  = (k < 39*H) || (chain && k > wk);
            ed  = (k == 40*H - 1);
            check(tag, {28'd0, tx_out_p, tx_out_n, tx_busy, tx_done},
                  {28'd0, lvl, ~lvl, eb, ed});
            if (chain && k == wk) drive(nd, ncd, ninj);
            else if (k == stray_k) drive(stray_d, 1'($urandom), 1'($urandom));
            tick();
            scramble();
        end
    endtask

    initial begin
        logic [15:0] d, nd;
        logic        cd, ncd, inj, ninj, chain;
        int          stray;

        reset = 1'b0;
        scramble();
        #3;
        check("reset", {28'd0, tx_out_p, tx_out_n, tx_busy, tx_done}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        tick();
        check_idle("idle", 2);

        // Command sync, parity 0
        start_idle(16'h0821, 1'b0, 1'b0);
        run_word("t1", 16'h0821, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, -1, -1, 16'h0, -1);
        check_idle("t1_idle", 3);

        // Data sync, all ones, parity 1
        start_idle(16'hFFFF, 1'b1, 1'b0);
        run_word("t2", 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, -1, -1, 16'h0, -1);
        check_idle("t2_idle", 3);

        // Back-to-back, second strobe on the tx_done cycle
        start_idle(16'h0821, 1'b0, 1'b0);
        run_word("t3a", 16'h0821, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 40*H - 1, -1,
                 16'h0, -1);
        run_word("t3b", 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, -1, -1, 16'h0, -1);
        check_idle("t3_idle", 3);

        // Strobe mid-DATA is ignored
        start_idle(16'h5A0F, 1'b0, 1'b0);
        run_word("t4", 16'h5A0F, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, -1, 22*H, 16'hAAAA, -1);
        check_idle("t4_idle", 4);

        // Asynchronous reset at half-bit 20
        start_idle(16'hC3A5, 1'b1, 1'b0);
        run_word("t5a", 16'hC3A5, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, -1, -1, 16'h0, 20*H + 3);
        #2 reset = 1'b0;
        #1 check("t5_async", {28'd0, tx_out_p, tx_out_n, tx_busy, tx_done}, 32'd0);
        tick();
        check("t5_held", {28'd0, tx_out_p, tx_out_n, tx_busy, tx_done}, 32'd0);
        #2 reset = 1'b1;
        tick();
        check_idle("t5_idle", 2);
        start_idle(16'h7E81, 1'b0, 1'b0);
        run_word("t5b", 16'h7E81, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, -1, -1, 16'h0, -1);
        check_idle("t5b_idle", 2);

`ifdef MKIO_TX_PARITY_INJECT_EN
        start_idle(16'h0001, 1'b0, 1'b1);
        run_word("t6a", 16'h0001, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, -1, -1, 16'h0, -1);
        run_word("t6b", 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, -1, -1, 16'h0, -1);
        check_idle("t6_idle", 2);
`endif

        // Random chains of words with stray strobes
        d   = 16'($urandom);
        cd  = 1'($urandom);
        inj = 1'($urandom);
        start_idle(d, cd, inj);
        for (int i = 0; i < 12; i++) begin
            chain = (i != 11) && ($urandom_range(0, 1) == 1);
            nd    = 16'($urandom);
            ncd   = 1'($urandom);
            ninj  = 1'($urandom);
            stray = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 39*H - 1)) : -1;
            run_word("rand", d, cd, inj, chain, nd, ncd, ninj, -1, stray, 16'($urandom), -1);
            if (!chain) begin
                check_idle("rand_idle", 2 + $urandom_range(0, 3));
                if (i != 11) start_idle(nd, ncd, ninj);
            end
            d   = nd;
            cd  = ncd;
            inj = ninj;
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
